// File: rtl/ring_pkg.sv
// ring_pkg: shared state encoding and default cadence for the ring cadence generator.
package ring_pkg;
   typedef enum logic [1:0] {IDLE, RING_ON, RING_OFF} ring_state_t;
   localparam int DEF_ON_CYCLES  = 4;
   localparam int DEF_OFF_CYCLES = 8;
   localparam int DEF_MAX_BURSTS = 5;
   function automatic int cycles_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction
endpackage

// File: rtl/phase_timer.sv
// phase_timer: loadable down-counter; done marks the last cycle of the loaded phase.
module phase_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);
   logic [W-1:0] cnt;
   always_ff @(posedge clk or posedge reset)
      if (reset) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (cnt != '0) cnt <= cnt - W'(1);
   assign done = cnt == W'(1);
endmodule

// File: rtl/ring_cadence_gen.sv
// ring_cadence_gen: ring-on/silent-gap cadence for an incoming call, with missed-call pulse.
module ring_cadence_gen
   import ring_pkg::*;
#(
   parameter int ON_CYCLES  = DEF_ON_CYCLES,
   parameter int OFF_CYCLES = DEF_OFF_CYCLES,
   parameter int MAX_BURSTS = DEF_MAX_BURSTS
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            call_in,
   input  logic                            answer,
   input  logic                            hangup,
   output logic                            ring,
   output logic                            busy,
   output logic                            missed,
   output logic [$clog2(MAX_BURSTS+1)-1:0] burst_cnt
);
   localparam int BW = $clog2(MAX_BURSTS + 1);
   localparam int TW = $clog2(cycles_max(ON_CYCLES, OFF_CYCLES) + 1);
   ring_state_t   state, state_nx;
   logic [BW-1:0] burst_nx;
   logic [TW-1:0] load_val;
   logic          load, done, stop, missed_nx;
   assign stop = answer | hangup;
   phase_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .load_val (load_val),
      .done     (done)
   );
   // answer/hangup outrank timer expiry, so a stopped call never reports missed
   always_comb begin
      state_nx  = state;
      burst_nx  = burst_cnt;
      load      = 1'b0;
      load_val  = TW'(ON_CYCLES);
      missed_nx = 1'b0;
      case (state)
         IDLE:
            if (call_in) begin
               state_nx = RING_ON;
               load     = 1'b1;
               burst_nx = BW'(1);
            end
         RING_ON:
            if (stop) state_nx = IDLE;
            else if (done && burst_cnt == BW'(MAX_BURSTS)) begin
               state_nx  = IDLE;
               missed_nx = 1'b1;
            end else if (done) begin
               state_nx = RING_OFF;
               load     = 1'b1;
               load_val = TW'(OFF_CYCLES);
            end
         RING_OFF:
            if (stop) state_nx = IDLE;
            else if (done) begin
               state_nx = RING_ON;
               load     = 1'b1;
               burst_nx = burst_cnt + BW'(1);
            end
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state     <= IDLE;
         ring      <= 1'b0;
         busy      <= 1'b0;
         missed    <= 1'b0;
         burst_cnt <= '0;
      end else begin
         state     <= state_nx;
         ring      <= state_nx == RING_ON;
         busy      <= state_nx != IDLE;
         missed    <= missed_nx;
         burst_cnt <= burst_nx;
      end
endmodule
